// File: rtl/centroid_pkg.sv
// Shared widths, frame-size defaults and FSM encoding for the centroid block.
package centroid_pkg;
  localparam int IMG_W_DEF = 1280;
  localparam int IMG_H_DEF = 720;
  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int M_W       = 20;
  localparam int MX_W      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_X  = 2'd1,
    DIV_Y  = 2'd2,
    UPDATE = 2'd3
  } state_t;
endpackage

// File: rtl/centroid_calc_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock; done is high exactly
// MX_W cycles after start with the quotient valid in that cycle.
module seq_divider
  import centroid_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MX_W-1:0] dividend,
  input  logic [M_W-1:0]  divisor,
  output logic [MX_W-1:0] quotient,
  output logic            done
);
  localparam int CNT_W = $clog2(MX_W + 1);

  logic [M_W-1:0]   rem_q, rem_d;
  logic [MX_W-1:0]  quo_q, quo_d;
  logic [M_W-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract when it fits. The low M_W bits of the difference are exact
  // because a successful subtraction always leaves a remainder below divisor.
  function automatic logic [M_W+MX_W-1:0] div_step(
    input logic [M_W-1:0]  rem,
    input logic [MX_W-1:0] quo,
    input logic [M_W-1:0]  dvs
  );
    logic [M_W:0]   trial;
    logic [M_W-1:0] diff;
    trial = {rem, quo[MX_W-1]};
    diff  = trial[M_W-1:0] - dvs;
    if (trial >= {1'b0, dvs})
      return {diff, quo[MX_W-2:0], 1'b1};
    else
      return {trial[M_W-1:0], quo[MX_W-2:0], 1'b0};
  endfunction

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      {rem_d, quo_d} = div_step('0, dividend, divisor);
      dvs_d          = divisor;
      cnt_d          = CNT_W'(1);
      active_d       = 1'b1;
    end else if (active_q) begin
      if (cnt_q == CNT_W'(MX_W)) begin
        active_d = 1'b0;
      end else begin
        {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
        cnt_d          = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign done     = active_q && (cnt_q == CNT_W'(MX_W));
  assign quotient = quo_q;
endmodule

// File: rtl/centroid_calc.sv
// Frame centroid of a binary mask: moments accumulate while pixels stream,
// then one shared sequential divider produces x and y at end of frame.
module centroid_calc
  import centroid_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           de,
  input  logic           vsync,
  input  logic           hsync,
  input  logic [23:0]    mask,
  output logic [X_W-1:0] xcent,
  output logic [Y_W-1:0] ycent,
  output logic           cent_valid,
  output logic           busy
);
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [M_W-1:0]  m_q, m_d;
  logic [MX_W-1:0] mx_q, mx_d;
  logic [MX_W-1:0] my_q, my_d;
  logic            vs_prev_q;
  logic [M_W-1:0]  op_m_q;
  logic [MX_W-1:0] op_mx_q, op_my_q;
  logic [X_W-1:0]  qx_q;
  logic            start_q;
  logic [X_W-1:0]  xcent_q;
  logic [Y_W-1:0]  ycent_q;
  logic            valid_q;
  state_t          state_q, state_d;

  logic            eof, accept;
  logic            div_start, div_done;
  logic [MX_W-1:0] div_dividend, div_quot;
  logic            unused_bits;

  assign unused_bits = ^{hsync, mask[23:1], div_quot[MX_W-1:X_W]};

  assign eof    = vsync && !vs_prev_q;
  // A frame ending while a division runs is dropped so its operands never
  // overwrite the ones still being divided.
  assign accept = eof && (state_q == IDLE) && (m_q != '0);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vsync) begin
      x_d = '0;
      y_d = '0;
    end else if (de) begin
      if (x_q == X_W'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (y_q == Y_W'(IMG_H - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    m_d  = m_q;
    mx_d = mx_q;
    my_d = my_q;
    if (eof) begin
      m_d  = '0;
      mx_d = '0;
      my_d = '0;
    end else if (de && !vsync && mask[0]) begin
      m_d  = m_q + 1'b1;
      mx_d = mx_q + MX_W'(x_q);
      my_d = my_q + MX_W'(y_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    div_start = start_q;
    case (state_q)
      IDLE:   if (accept) state_d = DIV_X;
      DIV_X:  if (div_done) begin
                state_d   = DIV_Y;
                div_start = 1'b1;
              end
      DIV_Y:  if (div_done) state_d = UPDATE;
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The Y division is launched in the same cycle the X quotient completes.
  assign div_dividend = (state_q == DIV_X && !div_done) ? op_mx_q : op_my_q;

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (op_m_q),
    .quotient (div_quot),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      m_q       <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      xcent_q   <= '0;
      ycent_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= accept;
      vs_prev_q <= vsync;
      x_q       <= x_d;
      y_q       <= y_d;
      m_q       <= m_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      valid_q   <= (state_q == UPDATE);
      if (state_q == UPDATE) begin
        xcent_q <= qx_q;
        ycent_q <= div_quot[Y_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_m_q  <= m_q;
      op_mx_q <= mx_q;
      op_my_q <= my_q;
    end
    if (state_q == DIV_X && div_done) qx_q <= div_quot[X_W-1:0];
  end

  assign xcent      = xcent_q;
  assign ycent      = ycent_q;
  assign cent_valid = valid_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_centroid_calc.sv
// Directed bench for centroid_calc on a reduced 128x64 frame so whole frames
// stream quickly; divider timing is independent of the frame size.
module tb_centroid_calc;
  localparam int W = 128;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst, de, vsync, hsync;
  logic [23:0] mask;
  logic [10:0] xcent;
  logic [9:0]  ycent;
  logic        cent_valid, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  centroid_calc #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .de         (de),
    .vsync      (vsync),
    .hsync      (hsync),
    .mask       (mask),
    .xcent      (xcent),
    .ycent      (ycent),
    .cent_valid (cent_valid),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_obj(input int pat, input int x, input int y);
    case (pat)
      1: return (x == 100) && (y == 50);
      2: return (x >= 63) && (x <= 65) && (y >= 31) && (y <= 33);
      3: return ((x == 10) || (x == 13)) && (y == 20);
      4: return 1'b1;
      5: return (x == 5) && (y == 7);
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams one full frame, then raises vsync; returns inside the eof cycle.
  task automatic run_frame(input int pat);
    vsync = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        de   = 1'b1;
        mask = is_obj(pat, x, y) ? 24'hFFFFFF : 24'h000000;
        step();
      end
    end
    de    = 1'b0;
    mask  = 24'h0;
    vsync = 1'b1;
  endtask

  task automatic expect_result(input string tag, input int ex, input int ey);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      step();
      n++;
      if (n == 1)  check({tag, "_busy_T1"}, busy, 1);
      if (n == 66) check({tag, "_busy_T66"}, busy, 1);
      if (cent_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, n, 67);
    check({tag, "_busy_T67"}, busy, 0);
    check({tag, "_xcent"}, xcent, ex);
    check({tag, "_ycent"}, ycent, ey);
    step();
    check({tag, "_pulse_len"}, cent_valid, 0);
  endtask

  initial begin
    int pulses;
    int busies;
    rst   = 1'b1;
    de    = 1'b0;
    vsync = 1'b1;
    hsync = 1'b0;
    mask  = 24'h0;
    repeat (3) step();
    check("rst_xcent", xcent, 0);
    check("rst_ycent", ycent, 0);
    check("rst_valid", cent_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) step();

    run_frame(1);
    expect_result("single", 100, 50);

    run_frame(0);
    pulses = 0;
    busies = 0;
    repeat (100) begin
      step();
      if (cent_valid) pulses++;
      if (busy) busies++;
    end
    check("empty_pulses", pulses, 0);
    check("empty_busy", busies, 0);
    check("empty_xhold", xcent, 100);
    check("empty_yhold", ycent, 50);

    run_frame(2);
    expect_result("block", 64, 32);

    run_frame(3);
    expect_result("pair", 11, 20);

    // 128x64 all object: m_x=520192, m_y=258048, m=8192 -> 63.5, 31.5 floored
    run_frame(4);
    expect_result("white", 63, 31);

    run_frame(2);
    repeat (20) step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_xcent", xcent, 0);
    check("abort_ycent", ycent, 0);
    check("abort_valid", cent_valid, 0);
    pulses = 0;
    repeat (80) begin
      step();
      if (cent_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    run_frame(5);
    expect_result("after_rst", 5, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
